// File: rtl/rdcnt_exec_unit.sv
// Execute-stage unit for RDCNTVL.W / RDCNTVH.W / RDCNTID: owns the prescaled
// 64-bit stable counter and a one-entry valid/ready result buffer toward MEM/WB.

`ifndef OP_INVALID
`define OP_INVALID 8'h00
`endif
`ifndef OP_RDCNTVL
`define OP_RDCNTVL 8'h01
`endif
`ifndef OP_RDCNTVH
`define OP_RDCNTVH 8'h02
`endif
`ifndef OP_RDCNTID
`define OP_RDCNTID 8'h04
`endif

module rdcnt_exec_unit #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [63:0] CNT_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_op,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_pc,
  input  logic [31:0] tid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest,
  output logic        out_we,
  output logic        out_ine,
  output logic [31:0] out_pc,
  output logic [63:0] cnt_value
);

  localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

  logic [7:0]  pre;
  logic [63:0] cnt;
  logic        accept;
  logic        drain;
  logic [31:0] nxt_result;
  logic        nxt_we;
  logic        nxt_ine;

  // Free-running counter: independent of flush and handshake state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      cnt <= CNT_RESET;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      cnt <= cnt + 64'd1;
    end else begin
      pre <= pre + 8'd1;
    end
  end

  assign cnt_value = cnt;
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = out_valid && out_ready;

  always_comb begin
    nxt_result = '0;
    nxt_we     = 1'b0;
    nxt_ine    = 1'b0;
    case (in_op)
      `OP_RDCNTVL: begin nxt_result = cnt[31:0];  nxt_we = 1'b1; end
      `OP_RDCNTVH: begin nxt_result = cnt[63:32]; nxt_we = 1'b1; end
      `OP_RDCNTID: begin nxt_result = tid;        nxt_we = 1'b1; end
      default:     nxt_ine = 1'b1;
    endcase
    // r0 is hardwired zero; the exception flag is still reported.
    if (in_dest == 5'd0) nxt_we = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dest   <= '0;
      out_we     <= 1'b0;
      out_ine    <= 1'b0;
      out_pc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= nxt_result;
      out_dest   <= in_dest;
      out_we     <= nxt_we;
      out_ine    <= nxt_ine;
      out_pc     <= in_pc;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rdcnt_exec_unit.sv
// Scoreboard bench for rdcnt_exec_unit: two instances (PRESCALE 1 and 4) share stimulus;
// expected results come from an edge-count counter model and a one-deep buffer model.

module tb_rdcnt_exec_unit;

  localparam logic [7:0]  OPC_INVALID = 8'h00;
  localparam logic [7:0]  OPC_VL      = 8'h01;
  localparam logic [7:0]  OPC_VH      = 8'h02;
  localparam logic [7:0]  OPC_ID      = 8'h04;
  localparam logic [63:0] RST_A       = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] RST_B       = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_op = '0;
  logic [4:0]  in_dest = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] tid = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_we, out_ine;
  logic [31:0] out_result, out_pc;
  logic [4:0]  out_dest;
  logic [63:0] cnt_a;

  logic        b_in_ready, b_out_valid, b_out_we, b_out_ine;
  logic [31:0] b_out_result, b_out_pc;
  logic [4:0]  b_out_dest;
  logic [63:0] cnt_b;

  always #5 clk = ~clk;

  rdcnt_exec_unit #(.PRESCALE(1), .CNT_RESET(RST_A)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dest(in_dest), .in_pc(in_pc), .tid(tid), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_dest(out_dest), .out_we(out_we),
    .out_ine(out_ine), .out_pc(out_pc), .cnt_value(cnt_a)
  );

  rdcnt_exec_unit #(.PRESCALE(4), .CNT_RESET(RST_B)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_op(in_op), .in_dest(in_dest), .in_pc(in_pc), .tid(tid), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_result(b_out_result), .out_dest(b_out_dest), .out_we(b_out_we),
    .out_ine(b_out_ine), .out_pc(b_out_pc), .cnt_value(cnt_b)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        we;
    logic        ine;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic        mv = 1'b0;
  longint unsigned ncyc;

  // Number of clock edges since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] model_cnt(input logic [63:0] base, input longint unsigned ps);
    return base + 64'(ncyc / ps);
  endfunction

  function automatic exp_t model_entry(input logic [7:0] op, input logic [4:0] dest,
                                       input logic [31:0] pc, input logic [31:0] t);
    exp_t e;
    logic [63:0] c;
    c      = model_cnt(RST_A, 1);
    e.dest = dest;
    e.pc   = pc;
    e.res  = '0;
    e.we   = 1'b0;
    e.ine  = 1'b0;
    if (op == OPC_VL)      begin e.res = c[31:0];  e.we = 1'b1; end
    else if (op == OPC_VH) begin e.res = c[63:32]; e.we = 1'b1; end
    else if (op == OPC_ID) begin e.res = t;        e.we = 1'b1; end
    else                   e.ine = 1'b1;
    if (dest == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  task automatic step(input logic v, input logic [7:0] op, input logic [4:0] dest,
                      input logic fl, input logic ordy);
    logic acc;
    @(negedge clk);
    in_valid  = v;
    in_op     = op;
    in_dest   = dest;
    in_pc     = $urandom;
    tid       = $urandom;
    flush     = fl;
    out_ready = ordy;
    acc = v && (!mv || ordy) && !fl;
    if (fl)       q.delete();
    else if (acc) q.push_back(model_entry(op, dest, in_pc, tid));
    #1;
    chk("in_ready", in_ready, !mv || ordy);
    chk("out_valid", out_valid, mv);
    chk("cnt_a", cnt_a, model_cnt(RST_A, 1));
    chk("cnt_b", cnt_b, model_cnt(RST_B, 4));
    if (fl)                mv = 1'b0;
    else if (acc)          mv = 1'b1;
    else if (mv && ordy)   mv = 1'b0;
  endtask

  task automatic chk_cleared();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_ine", out_ine, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_cnt_a", cnt_a, RST_A);
    chk("rst_cnt_b", cnt_b, RST_B);
  endtask

  // Monitor: every live output cycle must match the oldest outstanding expectation.
  always begin
    @(negedge clk);
    #1;
    if (!reset && !flush && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        chk("out_result", out_result, q[0].res);
        chk("out_dest", out_dest, q[0].dest);
        chk("out_we", out_we, q[0].we);
        chk("out_ine", out_ine, q[0].ine);
        chk("out_pc", out_pc, q[0].pc);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 4))
      0: return OPC_VL;
      1: return OPC_VH;
      2: return OPC_ID;
      3: return OPC_INVALID;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk_cleared();
    @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back VH then VL across the low-word carry.
    step(1, OPC_VH, 5'd5, 0, 1);
    step(1, OPC_VL, 5'd6, 0, 1);
    // r0 destination and an undefined op.
    step(1, OPC_ID, 5'd0, 0, 1);
    step(1, OPC_INVALID, 5'd7, 0, 1);
    step(0, OPC_INVALID, 5'd0, 0, 1);
    // Stall for four cycles, flush on the third with a new instruction offered.
    step(1, OPC_VL, 5'd5, 0, 0);
    step(1, OPC_VH, 5'd9, 0, 0);
    step(1, OPC_VH, 5'd9, 0, 0);
    step(1, OPC_ID, 5'd9, 1, 0);
    step(1, OPC_VL, 5'd9, 0, 0);
    step(0, OPC_VL, 5'd9, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 3) != 0, rand_op(), d,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in the middle of a stall clears the buffer without a clock edge.
    step(1, OPC_VL, 5'd3, 0, 0);
    step(0, OPC_VL, 5'd3, 0, 0);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    chk_cleared();
    q.delete();
    mv = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) step(1, OPC_VL, 5'd4, 0, 1);
    step(0, OPC_VL, 5'd4, 0, 1);
    step(0, OPC_VL, 5'd4, 0, 1);
    chk("queue_empty", 64'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
